// File: rtl/thcomp_seq.sv
// thcomp_seq: initiator side of the threshold-comparator handshake.
//
// Takes a stream of correlation metrics. Each accepted metric is written,
// together with the threshold sampled at accept time, into the comparator
// operand registers. The sequencer then pulses the comparator start and waits
// for finish. Consecutive above-threshold results are counted, and frame sync
// is declared after HIT_COUNT of them in a row. A comparator that does not
// answer within TIMEOUT wait cycles is reported as a timeout and treated as a
// miss.
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   enable                 sequencer enable (low in IDLE clears the run state)
//   sample_valid/metric    incoming metric stream
//   sample_ready           metric can be accepted (IDLE && enable && !rst)
//   threshold              sync threshold, sampled on accept
//   seq_thcompregs_*       operand register write strobe and operands
//   seq_thcomp_start       comparator start pulse
//   thcomp_seq_finish/data comparator done pulse and result (metric > threshold)
//   sync_found/sync_index  sync pulse and index of the sample that completed it
//   timeout_err            comparator timeout pulse
//   busy                   sequencer is not in IDLE
module thcomp_seq #(
    parameter int DATA_W    = 16,
    parameter int HIT_COUNT = 3,
    parameter int IDX_W     = 12,
    parameter int TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_metric,
    input  logic [DATA_W-1:0] threshold,
    output logic              sample_ready,
    output logic              seq_thcompregs_we,
    output logic [DATA_W-1:0] seq_thcompregs_data0,
    output logic [DATA_W-1:0] seq_thcompregs_data1,
    output logic              seq_thcomp_start,
    input  logic              thcomp_seq_finish,
    input  logic              thcomp_seq_data,
    output logic              sync_found,
    output logic [IDX_W-1:0]  sync_index,
    output logic              timeout_err,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_EVAL
    } state_t;

    // Timer counts from 0 on WAIT entry; abort on the edge where it would
    // reach TIMEOUT, so the error is visible TIMEOUT cycles after WAIT entry.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [4:0] HIT_TGT  = 5'(HIT_COUNT);

    state_t              state_q;
    logic [3:0]          hit_cnt_q;
    logic [IDX_W-1:0]    sample_idx_q;
    logic [7:0]          timer_q;
    logic                result_q;
    logic                we_q;
    logic                start_q;
    logic [DATA_W-1:0]   data0_q;
    logic [DATA_W-1:0]   data1_q;
    logic                sync_q;
    logic [IDX_W-1:0]    sync_idx_q;
    logic                tmo_q;

    logic [4:0]          hit_next_d;
    logic [IDX_W-1:0]    idx_next_d;

    assign hit_next_d = {1'b0, hit_cnt_q} + 5'd1;
    assign idx_next_d = sample_idx_q + IDX_W'(1);   // wraps silently

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            hit_cnt_q    <= '0;
            sample_idx_q <= '0;
            timer_q      <= '0;
            result_q     <= 1'b0;
            we_q         <= 1'b0;
            start_q      <= 1'b0;
            data0_q      <= '0;
            data1_q      <= '0;
            sync_q       <= 1'b0;
            sync_idx_q   <= '0;
            tmo_q        <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            we_q    <= 1'b0;
            start_q <= 1'b0;
            sync_q  <= 1'b0;
            tmo_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!enable) begin
                        hit_cnt_q    <= '0;
                        sample_idx_q <= '0;
                    end else if (sample_valid) begin
                        // Operands go straight into the output registers so
                        // they are presented with the write strobe in LOAD.
                        data0_q <= sample_metric;
                        data1_q <= threshold;
                        we_q    <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    start_q <= 1'b1;
                    state_q <= S_START;
                end
                S_START: begin
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // Finish takes priority over an expiring timer.
                    if (thcomp_seq_finish) begin
                        result_q <= thcomp_seq_data;
                        state_q  <= S_EVAL;
                    end else if (timer_q == TMO_LAST) begin
                        tmo_q        <= 1'b1;
                        hit_cnt_q    <= '0;
                        sample_idx_q <= idx_next_d;
                        state_q      <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                S_EVAL: begin
                    if (result_q) begin
                        if (hit_next_d == HIT_TGT) begin
                            sync_q     <= 1'b1;
                            sync_idx_q <= sample_idx_q;
                            hit_cnt_q  <= '0;
                        end else begin
                            hit_cnt_q <= hit_next_d[3:0];
                        end
                    end else begin
                        hit_cnt_q <= '0;
                    end
                    sample_idx_q <= idx_next_d;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sample_ready         = (state_q == S_IDLE) && enable && !rst;
    assign busy                 = (state_q != S_IDLE);
    assign seq_thcompregs_we    = we_q;
    assign seq_thcompregs_data0 = data0_q;
    assign seq_thcompregs_data1 = data1_q;
    assign seq_thcomp_start     = start_q;
    assign sync_found           = sync_q;
    assign sync_index           = sync_idx_q;
    assign timeout_err          = tmo_q;

endmodule

// File: tb/tb_thcomp_seq.sv
module tb_thcomp_seq;
    localparam int DW = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b1;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] sample_metric = '0;
    logic [DW-1:0] threshold = '0;
    logic          thcomp_seq_finish = 1'b0;
    logic          thcomp_seq_data = 1'b0;
    logic          sample_ready, seq_thcompregs_we, seq_thcomp_start;
    logic [DW-1:0] seq_thcompregs_data0, seq_thcompregs_data1;
    logic          sync_found, timeout_err, busy;
    logic [IW-1:0] sync_index;

    thcomp_seq #(.DATA_W(DW), .HIT_COUNT(3), .IDX_W(IW), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .sample_valid(sample_valid), .sample_metric(sample_metric),
        .threshold(threshold), .sample_ready(sample_ready),
        .seq_thcompregs_we(seq_thcompregs_we),
        .seq_thcompregs_data0(seq_thcompregs_data0),
        .seq_thcompregs_data1(seq_thcompregs_data1),
        .seq_thcomp_start(seq_thcomp_start),
        .thcomp_seq_finish(thcomp_seq_finish), .thcomp_seq_data(thcomp_seq_data),
        .sync_found(sync_found), .sync_index(sync_index),
        .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected event: sync (with index) or timeout, and the cycle it shows up.
    typedef struct {
        bit is_sync;
        int idx;
        int at;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int st_cnt = 0;
    int cmp_delay = 1;   // 0 = comparator never answers
    int acc_cyc = 0;
    logic [DW-1:0] exp_d0 = '0;
    logic [DW-1:0] exp_d1 = '0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int outs_or();
        return int'(|{seq_thcompregs_we, seq_thcomp_start, seq_thcompregs_data0,
                      seq_thcompregs_data1, sync_found, sync_index, timeout_err, busy});
    endfunction

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (seq_thcompregs_we) begin
                    we_cnt++;
                    check("data0", int'(seq_thcompregs_data0), int'(exp_d0));
                    check("data1", int'(seq_thcompregs_data1), int'(exp_d1));
                end
                if (seq_thcomp_start) st_cnt++;
                if (sync_found || timeout_err) begin
                    check("sync_and_timeout_exclusive", int'(sync_found && timeout_err), 0);
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event sync %0d timeout %0d idx %0d cycle %0d",
                                 sync_found, timeout_err, sync_index, cyc);
                    end else begin
                        e = q.pop_front();
                        check("event_is_sync", int'(sync_found), int'(e.is_sync));
                        if (e.is_sync) check("sync_index", int'(sync_index), e.idx);
                        check("event_cycle", cyc, e.at);
                    end
                end
            end
        end
    endtask

    // Comparator model: answers d cycles after seeing start.
    task automatic cmp_loop();
        int d;
        logic r;
        forever begin
            @(negedge clk);
            if (seq_thcomp_start && cmp_delay != 0) begin
                d = cmp_delay;
                r = exp_d0 > exp_d1;
                repeat (d) @(negedge clk);
                thcomp_seq_finish = 1'b1;
                thcomp_seq_data   = r;
                @(negedge clk);
                thcomp_seq_finish = 1'b0;
                thcomp_seq_data   = 1'b0;
            end
        end
    endtask

    // kind: 0 = no event, 1 = sync at idx, 2 = timeout
    task automatic send(input int m, input int t, input int d, input int kind, input int idx);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!sample_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!sample_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_wait actual 0 required 1 (cycle %0d)", cyc);
            return;
        end
        cmp_delay     = d;
        sample_valid  = 1'b1;
        sample_metric = DW'(m);
        threshold     = DW'(t);
        exp_d0        = DW'(m);
        exp_d1        = DW'(t);
        acc_cyc       = cyc;
        if (kind == 1) begin
            e.is_sync = 1'b1; e.idx = idx; e.at = cyc + d + 4;
            q.push_back(e);
        end else if (kind == 2) begin
            e.is_sync = 1'b0; e.idx = 0; e.at = cyc + 18;
            q.push_back(e);
        end
        @(negedge clk);
        sample_valid  = 1'b0;
        sample_metric = 16'hAAAA;
        threshold     = 16'h5555;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 60) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("drain_queue_empty", q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready_low", int'(sample_ready), 0);
        check("rst_outputs_zero", outs_or(), 0);
        check("rst_queue_empty", q.size(), 0);
        rst = 1'b0;
    endtask

    initial begin
        int w0, s0, a1;
        fork
            monitor_loop();
            cmp_loop();
        join_none

        // 1: three hits, nominal latency and strobe counts
        do_reset();
        w0 = we_cnt;
        s0 = st_cnt;
        send(10, 5, 1, 0, 0);
        a1 = acc_cyc;
        send(20, 5, 1, 0, 0);
        check("throughput_5_cycles", acc_cyc - a1, 5);
        send(30, 5, 1, 1, 2);
        drain();
        check("we_pulses", we_cnt - w0, 3);
        check("start_pulses", st_cnt - s0, 3);

        // 2: a miss breaks the run
        do_reset();
        send(10, 5, 1, 0, 0);
        send(2, 5, 1, 0, 0);
        send(10, 5, 1, 0, 0);
        send(10, 5, 1, 0, 0);
        send(10, 5, 1, 1, 4);
        drain();

        // 3: comparator never answers; run restarts from zero hits
        do_reset();
        send(10, 5, 1, 0, 0);
        send(10, 5, 1, 0, 0);
        send(10, 5, 0, 2, 0);
        send(10, 5, 1, 0, 0);
        send(10, 5, 1, 0, 0);
        send(10, 5, 1, 1, 5);
        drain();

        // 4: finish on the expiring cycle wins; one cycle later is a timeout
        do_reset();
        send(10, 5, 1, 0, 0);
        send(10, 5, 1, 0, 0);
        send(10, 5, 15, 1, 2);
        send(10, 5, 16, 2, 0);
        send(10, 5, 1, 0, 0);
        send(10, 5, 1, 0, 0);
        send(10, 5, 1, 1, 6);
        drain();

        // 5: reset in WAIT after two hits
        do_reset();
        send(10, 5, 1, 0, 0);
        send(10, 5, 1, 0, 0);
        send(10, 5, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("busy_in_wait", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_outputs_zero", outs_or(), 0);
        check("mid_rst_ready_low", int'(sample_ready), 0);
        rst = 1'b0;
        send(10, 5, 1, 0, 0);
        send(10, 5, 1, 0, 0);
        send(10, 5, 1, 1, 2);
        drain();

        // 6: index wraps at 2^IDX_W
        do_reset();
        for (int i = 0; i < 17; i++) send(2, 5, 1, 0, 0);
        send(10, 5, 1, 0, 0);
        send(10, 5, 1, 0, 0);
        send(10, 5, 1, 1, 3);
        drain();

        // 7: enable low for one idle cycle clears index and hit count
        do_reset();
        send(10, 5, 1, 0, 0);
        send(10, 5, 1, 0, 0);
        drain();
        enable = 1'b0;
        @(negedge clk);
        check("ready_enable_low", int'(sample_ready), 0);
        enable = 1'b1;
        send(10, 5, 1, 0, 0);
        send(10, 5, 1, 0, 0);
        send(10, 5, 1, 1, 2);
        drain();

        repeat (20) @(negedge clk);
        check("final_queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
